// File: rtl/bout_scheduler_if.sv
// Exchange handshake between the bout scheduler and the per-frame action FSM.
// The scheduler side (master) strobes go and holds reset; the action FSM side reports touches.
interface bout_scheduler_if;
   logic sync_valid_in;
   logic fsm_valid_in;
   logic player_scored_in;
   logic opponent_scored_in;
   logic fsm_go_out;
   logic fsm_rst_out;

   modport master (
      input  sync_valid_in,
      input  fsm_valid_in,
      input  player_scored_in,
      input  opponent_scored_in,
      output fsm_go_out,
      output fsm_rst_out
   );

   modport slave (
      output sync_valid_in,
      output fsm_valid_in,
      output player_scored_in,
      output opponent_scored_in,
      input  fsm_go_out,
      input  fsm_rst_out
   );
endinterface

// File: rtl/bout_scheduler.sv
// Fencing bout controller: countdown, one-exchange-at-a-time gating of the action FSM,
// exchange timeout, touch scoring, pauses and winner declaration. All outputs registered.
module bout_scheduler #(
   parameter int unsigned POINTS_TO_WIN    = 5,
   parameter int unsigned COUNTDOWN_FRAMES = 180,
   parameter int unsigned PAUSE_FRAMES     = 90,
   parameter int unsigned FSM_TIMEOUT      = 16
) (
   input  logic             clk_pixel_in,
   input  logic             rst_n_in,
   input  logic             start_in,
   input  logic             abort_in,
   input  logic             frame_start_in,
   bout_scheduler_if.master fsm_bus,
   output logic [3:0]       player_score_out,
   output logic [3:0]       opponent_score_out,
   output logic [2:0]       phase_out,
   output logic [1:0]       winner_out,
   output logic             double_touch_out,
   output logic             timeout_err_out
);

   localparam int unsigned FRAME_MAX = (COUNTDOWN_FRAMES > PAUSE_FRAMES) ? COUNTDOWN_FRAMES : PAUSE_FRAMES;
   localparam int FRAME_BITS = $clog2(FRAME_MAX + 1);
   localparam int FRAME_W    = (FRAME_BITS < 8) ? 8 : FRAME_BITS;
   localparam int CYC_W      = $clog2(FSM_TIMEOUT + 1);

   localparam logic [FRAME_W-1:0] CD_LAST    = FRAME_W'(COUNTDOWN_FRAMES - 1);
   localparam logic [FRAME_W-1:0] PAUSE_LAST = FRAME_W'(PAUSE_FRAMES - 1);
   localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(FSM_TIMEOUT - 1);
   localparam logic [CYC_W-1:0]   CYC_ONE    = CYC_W'(1);
   localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
   localparam logic [3:0]         WIN_SCORE  = 4'(POINTS_TO_WIN);

   localparam logic [1:0] WIN_NONE   = 2'b00;
   localparam logic [1:0] WIN_PLAYER = 2'b01;
   localparam logic [1:0] WIN_OPP    = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_WAIT_SYNC = 3'd2,
      ST_WAIT_FSM  = 3'd3,
      ST_PAUSE     = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   state_t             state_r, state_s;
   logic [FRAME_W-1:0] frame_cnt_r, frame_cnt_s;
   logic [CYC_W-1:0]   cyc_cnt_r, cyc_cnt_s;
   logic [3:0]         player_score_r, player_score_s;
   logic [3:0]         opponent_score_r, opponent_score_s;
   logic [1:0]         winner_r, winner_s;
   logic               go_r, go_s;
   logic               fsm_rst_r, fsm_rst_s;
   logic               double_r, double_s;
   logic               timeout_err_r, timeout_err_s;
   logic [3:0]         player_inc_s;
   logic [3:0]         opponent_inc_s;

   // Saturating score increment; a score never passes the winning total.
   function automatic logic [3:0] score_inc(input logic [3:0] score);
      logic [3:0] result;
      if (score >= WIN_SCORE) begin
         result = WIN_SCORE;
      end else begin
         result = score + 4'd1;
      end
      return result;
   endfunction

   assign player_inc_s   = score_inc(player_score_r);
   assign opponent_inc_s = score_inc(opponent_score_r);

   // Next-state and next-output logic; abort overrides every other transition.
   always_comb begin
      state_s          = state_r;
      frame_cnt_s      = frame_cnt_r;
      cyc_cnt_s        = cyc_cnt_r;
      player_score_s   = player_score_r;
      opponent_score_s = opponent_score_r;
      winner_s         = winner_r;
      timeout_err_s    = timeout_err_r;
      go_s             = 1'b0;
      double_s         = 1'b0;

      if (abort_in) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_in) begin
                  player_score_s   = 4'd0;
                  opponent_score_s = 4'd0;
                  winner_s         = WIN_NONE;
                  timeout_err_s    = 1'b0;
                  frame_cnt_s      = {FRAME_W{1'b0}};
                  state_s          = ST_COUNTDOWN;
               end else begin
                  state_s = state_r;
               end
            end

            ST_COUNTDOWN: begin
               if (frame_start_in) begin
                  frame_cnt_s = frame_cnt_r + FRAME_ONE;
                  if (frame_cnt_r == CD_LAST) begin
                     state_s = ST_WAIT_SYNC;
                  end else begin
                     state_s = ST_COUNTDOWN;
                  end
               end else begin
                  state_s = ST_COUNTDOWN;
               end
            end

            ST_WAIT_SYNC: begin
               if (fsm_bus.sync_valid_in) begin
                  go_s      = 1'b1;
                  cyc_cnt_s = {CYC_W{1'b0}};
                  state_s   = ST_WAIT_FSM;
               end else begin
                  state_s = ST_WAIT_SYNC;
               end
            end

            ST_WAIT_FSM: begin
               cyc_cnt_s = cyc_cnt_r + CYC_ONE;
               // A valid result in the expiry cycle beats the timeout.
               if (fsm_bus.fsm_valid_in) begin
                  case ({fsm_bus.player_scored_in, fsm_bus.opponent_scored_in})
                     2'b10: begin
                        player_score_s = player_inc_s;
                        if (player_inc_s == WIN_SCORE) begin
                           winner_s = WIN_PLAYER;
                           state_s  = ST_DONE;
                        end else begin
                           frame_cnt_s = {FRAME_W{1'b0}};
                           state_s     = ST_PAUSE;
                        end
                     end
                     2'b01: begin
                        opponent_score_s = opponent_inc_s;
                        if (opponent_inc_s == WIN_SCORE) begin
                           winner_s = WIN_OPP;
                           state_s  = ST_DONE;
                        end else begin
                           frame_cnt_s = {FRAME_W{1'b0}};
                           state_s     = ST_PAUSE;
                        end
                     end
                     2'b11: begin
                        double_s    = 1'b1;
                        frame_cnt_s = {FRAME_W{1'b0}};
                        state_s     = ST_PAUSE;
                     end
                     default: begin
                        state_s = ST_WAIT_SYNC;
                     end
                  endcase
               end else if (cyc_cnt_r == CYC_LAST) begin
                  timeout_err_s = 1'b1;
                  state_s       = ST_WAIT_SYNC;
               end else begin
                  state_s = ST_WAIT_FSM;
               end
            end

            ST_PAUSE: begin
               if (frame_start_in) begin
                  frame_cnt_s = frame_cnt_r + FRAME_ONE;
                  if (frame_cnt_r == PAUSE_LAST) begin
                     state_s = ST_WAIT_SYNC;
                  end else begin
                     state_s = ST_PAUSE;
                  end
               end else begin
                  state_s = ST_PAUSE;
               end
            end

            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end

      // The action FSM runs only while an exchange may be in progress.
      fsm_rst_s = (state_s != ST_WAIT_SYNC) && (state_s != ST_WAIT_FSM);
   end

   // State register.
   always_ff @(posedge clk_pixel_in) begin
      if (!rst_n_in) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Counters, scores and registered output strobes.
   always_ff @(posedge clk_pixel_in) begin
      if (!rst_n_in) begin
         frame_cnt_r      <= {FRAME_W{1'b0}};
         cyc_cnt_r        <= {CYC_W{1'b0}};
         player_score_r   <= 4'd0;
         opponent_score_r <= 4'd0;
         winner_r         <= WIN_NONE;
         timeout_err_r    <= 1'b0;
         go_r             <= 1'b0;
         double_r         <= 1'b0;
         fsm_rst_r        <= 1'b1;
      end else begin
         frame_cnt_r      <= frame_cnt_s;
         cyc_cnt_r        <= cyc_cnt_s;
         player_score_r   <= player_score_s;
         opponent_score_r <= opponent_score_s;
         winner_r         <= winner_s;
         timeout_err_r    <= timeout_err_s;
         go_r             <= go_s;
         double_r         <= double_s;
         fsm_rst_r        <= fsm_rst_s;
      end
   end

   assign phase_out          = state_r;
   assign player_score_out   = player_score_r;
   assign opponent_score_out = opponent_score_r;
   assign winner_out         = winner_r;
   assign double_touch_out   = double_r;
   assign timeout_err_out    = timeout_err_r;
   assign fsm_bus.fsm_go_out  = go_r;
   assign fsm_bus.fsm_rst_out = fsm_rst_r;

endmodule
